// File: rtl/bus_fabric.sv
// Registered request/acknowledge interconnect from one load/store master to NSLV
// memory-mapped slaves. Define BUS_TIMEOUT_EN to terminate hung accesses with an error.
module bus_fabric #(
  parameter int                   NSLV        = 4,
  parameter int                   AW          = 32,
  parameter int                   DW          = 32,
  parameter logic [NSLV*AW-1:0]   SLV_BASE    = '0,
  parameter logic [NSLV*AW-1:0]   SLV_MASK    = '0,
  parameter int                   DEFAULT_SLV = NSLV - 1,
  parameter int                   TIMEOUT     = 255,
  parameter logic [DW-1:0]        ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m_req,
  input  logic                 m_wen,
  input  logic [AW-1:0]        m_addr,
  input  logic [DW-1:0]        m_wdata,
  output logic [DW-1:0]        m_rdata,
  output logic                 m_ack,
  output logic                 m_err,
  output logic                 m_busy,
  output logic [NSLV-1:0]      s_ren,
  output logic [NSLV-1:0]      s_wen,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wdata,
  input  logic [NSLV*DW-1:0]   s_rdata,
  input  logic [NSLV-1:0]      s_ack
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]      state;
  logic [SW-1:0]   sel;
  logic            wr;
  logic [SW-1:0]   dec_idx;
  logic [NSLV-1:0] dec_hot;
  logic            sel_ack;
  logic [DW-1:0]   sel_rdata;
  logic            timeout_hit;

  // Scan downwards so the lowest matching index overwrites any higher one.
  function automatic logic [SW-1:0] decode(input logic [AW-1:0] addr);
    logic [SW-1:0] idx;
    idx = SW'(DEFAULT_SLV);
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))
        idx = SW'(i);
    end
    return idx;
  endfunction

  assign dec_idx   = decode(m_addr);
  assign dec_hot   = NSLV'(1) << dec_idx;
  assign sel_ack   = s_ack[sel];
  assign sel_rdata = s_rdata[int'(sel)*DW +: DW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      wr      <= 1'b0;
      s_ren   <= '0;
      s_wen   <= '0;
      m_ack   <= 1'b0;
      m_busy  <= 1'b0;
      m_rdata <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      m_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (m_req) begin
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            sel     <= dec_idx;
            wr      <= m_wen;
            s_ren   <= m_wen ? '0 : dec_hot;
            s_wen   <= m_wen ? dec_hot : '0;
            m_busy  <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // An ack in the same cycle as the timeout takes priority.
          if (sel_ack) begin
            if (!wr) m_rdata <= sel_rdata;
            s_ren <= '0;
            s_wen <= '0;
            m_ack <= 1'b1;
            state <= DONE;
          end else if (timeout_hit) begin
            if (!wr) m_rdata <= ERR_DATA;
            s_ren <= '0;
            s_wen <= '0;
            m_ack <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          m_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          s_ren  <= '0;
          s_wen  <= '0;
          m_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // cnt counts completed wait cycles, so the limit is hit on the TIMEOUT-th one.
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == IDLE && m_req) begin
      cnt <= '0;
    end else if (state == ACCESS && !sel_ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_err <= 1'b0;
    end else if (state == ACCESS) begin
      if (sel_ack)          m_err <= 1'b0;
      else if (timeout_hit) m_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign m_err       = 1'b0;
  assign unused_cfg  = (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: decode, wait states, ignored foreign acks,
// timeout (when BUS_TIMEOUT_EN is defined) and asynchronous reset mid-access.
module tb_bus_fabric;

  localparam int NSLV    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;
  localparam logic [NSLV*AW-1:0] BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2010_0000};
  localparam logic [NSLV*AW-1:0] MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFF0_0000};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              m_req = 1'b0;
  logic              m_wen = 1'b0;
  logic [AW-1:0]     m_addr = '0;
  logic [DW-1:0]     m_wdata = '0;
  logic [DW-1:0]     m_rdata;
  logic              m_ack;
  logic              m_err;
  logic              m_busy;
  logic [NSLV-1:0]   s_ren;
  logic [NSLV-1:0]   s_wen;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [NSLV*DW-1:0] s_rdata;
  logic [NSLV-1:0]   s_ack = '0;

  int n_checks = 0;
  int n_fail   = 0;

  assign s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hA0A0_0000};

  bus_fabric #(
    .NSLV(NSLV), .AW(AW), .DW(DW), .SLV_BASE(BASE), .SLV_MASK(MASK),
    .DEFAULT_SLV(3), .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err), .m_busy(m_busy),
    .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Called in cycle 0; returns at the negedge of cycle 1 with m_req dropped.
  task automatic start(input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
    m_req   = 1'b1;
    m_wen   = wen;
    m_addr  = addr;
    m_wdata = wdata;
    cyc();
    m_req   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    cyc(); cyc();
    chk("rst_ren",   s_ren,   0);
    chk("rst_wen",   s_wen,   0);
    chk("rst_ack",   m_ack,   0);
    chk("rst_err",   m_err,   0);
    chk("rst_busy",  m_busy,  0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_saddr", s_addr,  0);
    reset = 1'b0;
    cyc();

    // Zero-wait read from slave 1
    s_ack = 4'b0010;
    start(1'b0, 32'h1000_0004, 32'h0);
    chk("zw_ren",   s_ren,  4'b0010);
    chk("zw_busy",  m_busy, 1);
    chk("zw_ack_c1", m_ack, 0);
    chk("zw_saddr", s_addr, 32'h1000_0004);
    cyc();
    chk("zw_ack",   m_ack,   1);
    chk("zw_rdata", m_rdata, 32'h1234_5678);
    chk("zw_err",   m_err,   0);
    chk("zw_ren_drop", s_ren, 0);
    s_ack = '0;
    cyc();
    chk("zw_ack_pulse", m_ack, 0);
    chk("zw_idle", m_busy, 0);

    // Write to slave 2 with three wait states, ack in cycle 4
    start(1'b1, 32'h2000_0008, 32'hCAFE_F00D);
    chk("ws_wdata", s_wdata, 32'hCAFE_F00D);
    chk("ws_ren",   s_ren,   0);
    for (int c = 1; c <= 4; c++) begin
      chk("ws_wen",   s_wen, 4'b0100);
      chk("ws_noack", m_ack, 0);
      if (c == 4) s_ack = 4'b0100;
      cyc();
    end
    chk("ws_ack",   m_ack,   1);
    chk("ws_rdata_kept", m_rdata, 32'h1234_5678);
    chk("ws_wen_drop", s_wen, 0);
    s_ack = '0;
    cyc();

    // Unmapped address falls to the default slave
    start(1'b0, 32'h7000_0000, 32'h0);
    chk("dflt_ren", s_ren, 4'b1000);
    s_ack = 4'b1000;
    cyc();
    chk("dflt_ack",   m_ack,   1);
    chk("dflt_rdata", m_rdata, 32'h3333_3333);
    s_ack = '0;
    cyc();

    // Address matching slaves 0 and 2: lowest index wins
    start(1'b0, 32'h2010_0040, 32'h0);
    chk("ovl_ren", s_ren, 4'b0001);
    s_ack = 4'b0001;
    cyc();
    chk("ovl_rdata", m_rdata, 32'hA0A0_0000);
    s_ack = '0;
    cyc();

    // Foreign ack ignored while slave 2 is selected; m_req held high throughout
    m_req = 1'b1; m_wen = 1'b0; m_addr = 32'h2000_0000;
    cyc();
    s_ack = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      chk("rb_ren",   s_ren, 4'b0100);
      chk("rb_noack", m_ack, 0);
      cyc();
    end
    chk("rb_ren_c4", s_ren, 4'b0100);
    s_ack = 4'b0100;
    cyc();
    chk("rb_ack",   m_ack,   1);
    chk("rb_rdata", m_rdata, 32'h2222_2222);
    m_req = 1'b0;
    s_ack = '0;
    cyc();
    chk("rb_one_ren", s_ren, 0);
    chk("rb_one_busy", m_busy, 0);
    cyc();
    chk("rb_one_ren2", s_ren, 0);
    chk("rb_one_busy2", m_busy, 0);

    // Ack arriving in the last wait cycle before the limit
    start(1'b0, 32'h1000_0000, 32'h0);
    for (int c = 1; c <= TIMEOUT; c++) begin
      chk("to8_ren",   s_ren, 4'b0010);
      chk("to8_noack", m_ack, 0);
      if (c == TIMEOUT) s_ack = 4'b0010;
      cyc();
    end
    chk("to8_ack",   m_ack,   1);
    chk("to8_err",   m_err,   0);
    chk("to8_rdata", m_rdata, 32'h1234_5678);
    s_ack = '0;
    cyc();

    // No ack at all
    start(1'b0, 32'h1000_0000, 32'h0);
    for (int c = 1; c <= TIMEOUT; c++) begin
      chk("to_ren", s_ren, 4'b0010);
      chk("to_noack", m_ack, 0);
      cyc();
    end
`ifdef BUS_TIMEOUT_EN
    chk("to_ack",   m_ack,   1);
    chk("to_err",   m_err,   1);
    chk("to_rdata", m_rdata, 32'hDEADBEEF);
    chk("to_ren_drop", s_ren, 0);
    cyc();
`else
    chk("nto_noack", m_ack, 0);
    chk("nto_ren",   s_ren, 4'b0010);
    chk("nto_err",   m_err, 0);
    s_ack = 4'b0010;
    cyc();
    chk("nto_ack",   m_ack,   1);
    chk("nto_err2",  m_err,   0);
    chk("nto_rdata", m_rdata, 32'h1234_5678);
    s_ack = '0;
    cyc();
`endif

    // Reset in cycle 2 of an access
    start(1'b0, 32'h3000_0000, 32'h0);
    chk("ra_ren", s_ren, 4'b1000);
    cyc();
    reset = 1'b1;
    #1;
    chk("ra_ren_async",  s_ren,  0);
    chk("ra_busy_async", m_busy, 0);
    chk("ra_ack_async",  m_ack,  0);
    cyc();
    reset = 1'b0;
    chk("ra_noack1", m_ack, 0);
    cyc();
    chk("ra_noack2", m_ack, 0);
    chk("ra_idle",   m_busy, 0);
    s_ack = 4'b0010;
    start(1'b0, 32'h1000_0004, 32'h0);
    chk("ra_next_ren", s_ren, 4'b0010);
    cyc();
    chk("ra_next_ack",   m_ack,   1);
    chk("ra_next_rdata", m_rdata, 32'h1234_5678);
    s_ack = '0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
